// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// the canonical NOP word and PC arithmetic constants.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the S_TRAP state).
package riscv_pkg;

   // Canonical RISC-V NOP: addi x0, x0, 0
   localparam logic [31:0] RV_NOP_INSTR  = 32'h0000_0013;
   // Distance between consecutive sequential fetch addresses
   localparam logic [31:0] PC_STEP       = 32'd4;
   // Clears the byte-offset bits so that every fetch address is word aligned
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
      , S_TRAP
`endif
   } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection for the fetch stage: a redirect target (word aligned)
// wins over the sequential pc+4, which wins over holding the current pc.
module pc_next_sel
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        redirect_take,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_next
);

   // Sequential address wraps naturally at 2^32
   assign pc_plus4 = pc + PC_STEP;

   // Priority mux: redirect, then sequential advance, else hold
   always_comb begin
      // NOTE: assign a default first so every path drives pc_next and no latch is inferred.
      pc_next = pc;
      if (redirect_take) begin
         pc_next = redirect_pc & PC_ALIGN_MASK;
      end else if (advance) begin
         pc_next = pc_plus4;
      end
   end

endmodule : pc_next_sel

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding instruction
// memory read at a time, holds the returned word for decode and accepts
// branch/jump redirects that squash any in-flight fetch.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect).
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pcplus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         kill_q, kill_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic [31:0]  instr_pcplus4_q, instr_pcplus4_d;

   logic         redirect_take;
   logic         advance;
   logic [31:0]  pc_plus4;
   logic [31:0]  pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic         fault_q, fault_d;
   logic         misaligned;
   assign misaligned  = redirect_take && (redirect_pc[1:0] != 2'b00);
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   // Redirects are honoured only while the stage is actively fetching
   assign redirect_take = redirect_valid &&
                          ((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_HOLD));
   // A live (unkilled) response advances the PC to the next word
   assign advance = (state_q == S_WAIT) && imem_rsp_valid && !kill_q;

   pc_next_sel u_pc_next_sel (
      .pc            (pc_q),
      .redirect_take (redirect_take),
      .redirect_pc   (redirect_pc),
      .advance       (advance),
      .pc_plus4      (pc_plus4),
      .pc_next       (pc_next)
   );

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_addr      = pc_q;
   assign instr_valid    = (state_q == S_HOLD);
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_pcplus4  = instr_pcplus4_q;

   // Next-state and capture logic for the single-outstanding fetch FSM
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_next;
      kill_d          = kill_q;
      instr_d         = instr_q;
      instr_pc_d      = instr_pc_q;
      instr_pcplus4_d = instr_pcplus4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d         = fault_q;
`endif

      case (state_q)
         S_IDLE: state_d = S_REQ;

         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
               // The accepted read targets the old PC; its response must be dropped
               if (redirect_take) kill_d = 1'b1;
            end
         end

         S_WAIT: begin
            if (redirect_take) begin
               if (imem_rsp_valid) begin
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (kill_q) begin
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  state_d         = S_HOLD;
                  instr_d         = imem_rsp_data;
                  instr_pc_d      = pc_q;
                  instr_pcplus4_d = pc_plus4;
               end
            end
         end

         S_HOLD: begin
            if (redirect_take || instr_ready) state_d = S_REQ;
         end

`ifdef FETCH_MISALIGN_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif

         default: state_d = S_IDLE;
      endcase

`ifdef FETCH_MISALIGN_TRAP_EN
      // A misaligned target overrides every other transition and parks the stage
      if (misaligned) begin
         state_d = S_TRAP;
         kill_d  = 1'b0;
         fault_d = 1'b1;
      end
`endif

      // Decode never sees a stale word once the held instruction is released
      if ((state_q == S_HOLD) && (state_d != S_HOLD)) instr_d = NOP_INSTR;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         state_q         <= S_IDLE;
         pc_q            <= RESET_PC;
         kill_q          <= 1'b0;
         instr_q         <= NOP_INSTR;
         instr_pc_q      <= 32'h0;
         instr_pcplus4_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q         <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         kill_q          <= kill_d;
         instr_q         <= instr_d;
         instr_pc_q      <= instr_pc_d;
         instr_pcplus4_q <= instr_pcplus4_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q         <= fault_d;
`endif
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small instruction-memory responder
// of programmable latency. Build with FETCH_MISALIGN_TRAP_EN to cover the trap.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pcplus4;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int          n_checks = 0;
   int          n_fail   = 0;

   // Memory responder state: latency in cycles after acceptance, pending request
   int          rsp_lat   = 1;
   int          pend_cnt  = 0;
   logic [31:0] pend_addr = 32'h0;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pcplus4  (instr_pcplus4),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory contents: a known ADDI at address 0, an address-tagged word elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (32'h0000_0013 | (a << 12));
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs and samples both sit 1 time unit after the edge
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (hs) begin
         pend_cnt  = rsp_lat;
         pend_addr = a;
      end
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
         end
      end
   endtask

   initial begin
      // NOTE: testbench drives use blocking assignments, placed away from the active edge.
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset state
      tick();
      tick();
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'd0);
      check("rst_instr", instr, NOP);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_pcplus4", instr_pcplus4, 32'h0);
      check("rst_fault", {31'h0, fetch_fault}, 32'd0);

      // Release: one IDLE cycle, then the first request at address 0
      reset = 1'b0;
      check("idle_req_valid", {31'h0, imem_req_valid}, 32'd0);
      tick();
      check("first_req_valid", {31'h0, imem_req_valid}, 32'd1);
      check("first_addr", imem_addr, 32'h0);
      tick();
      check("wait_req_valid", {31'h0, imem_req_valid}, 32'd0);
      check("wait_instr_valid", {31'h0, instr_valid}, 32'd0);
      tick();
      check("hold_instr_valid", {31'h0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h0050_0093);
      check("hold_instr_pc", instr_pc, 32'h0);
      check("hold_pcplus4", instr_pcplus4, 32'h4);

      // Back-pressure from decode: instruction stable, no new request
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_instr", instr, 32'h0050_0093);
         check("stall_no_req", {31'h0, imem_req_valid}, 32'd0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("consume_instr_valid", {31'h0, instr_valid}, 32'd0);
      check("consume_instr_nop", instr, NOP);
      check("next_req_valid", {31'h0, imem_req_valid}, 32'd1);
      check("next_addr", imem_addr, 32'h4);

      // Redirect in WAIT before the response: stale word must be dropped
      rsp_lat = 2;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      check("kill_wait_req", {31'h0, imem_req_valid}, 32'd0);
      check("kill_wait_valid", {31'h0, instr_valid}, 32'd0);
      tick();
      check("kill_drop_valid", {31'h0, instr_valid}, 32'd0);
      check("kill_req_valid", {31'h0, imem_req_valid}, 32'd1);
      check("kill_addr", imem_addr, 32'h100);
      rsp_lat = 1;
      tick();
      tick();
      check("redir_instr_valid", {31'h0, instr_valid}, 32'd1);
      check("redir_instr", instr, 32'h0010_0013);
      check("redir_instr_pc", instr_pc, 32'h100);
      check("redir_pcplus4", instr_pcplus4, 32'h104);

      // Redirect in HOLD coincident with instr_ready
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      instr_ready    = 1'b1;
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      check("hold_redir_valid", {31'h0, instr_valid}, 32'd0);
      check("hold_redir_instr", instr, NOP);
      check("hold_redir_req", {31'h0, imem_req_valid}, 32'd1);
      check("hold_redir_addr", imem_addr, 32'h100);

      // Memory not ready for 3 cycles: request and address held
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_req_valid", {31'h0, imem_req_valid}, 32'd1);
         check("stall_req_addr", imem_addr, 32'h100);
      end
      imem_req_ready = 1'b1;
      rsp_lat        = 3;
      tick();
      check("slow_wait_req", {31'h0, imem_req_valid}, 32'd0);

      // Reset in WAIT; the late response lands while IDLE and is ignored
      reset = 1'b1;
      tick();
      check("mid_rst_req", {31'h0, imem_req_valid}, 32'd0);
      check("mid_rst_addr", imem_addr, 32'h0);
      tick();
      reset = 1'b0;
      check("late_rsp_present", {31'h0, imem_rsp_valid}, 32'd1);
      rsp_lat = 1;
      tick();
      check("restart_valid", {31'h0, instr_valid}, 32'd0);
      check("restart_req", {31'h0, imem_req_valid}, 32'd1);
      check("restart_addr", imem_addr, 32'h0);
      tick();
      tick();
      check("restart_instr", instr, 32'h0050_0093);
      check("restart_instr_pc", instr_pc, 32'h0);
      check("restart_pcplus4", instr_pcplus4, 32'h4);

      // PC wrap: 0xFFFF_FFFC + 4 = 0
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      instr_ready    = 1'b1;
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      check("wrap_instr", instr, 32'hFFFF_C013);
      check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_pcplus4", instr_pcplus4, 32'h0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("wrap_next_addr", imem_addr, 32'h0);

      // Misaligned redirect while requesting without a handshake
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("trap_fault", {31'h0, fetch_fault}, 32'd1);
      check("trap_no_req", {31'h0, imem_req_valid}, 32'd0);
      check("trap_no_instr", {31'h0, instr_valid}, 32'd0);
      tick();
      tick();
      check("trap_sticky", {31'h0, fetch_fault}, 32'd1);
      check("trap_still_no_req", {31'h0, imem_req_valid}, 32'd0);
`else
      check("mask_fault", {31'h0, fetch_fault}, 32'd0);
      check("mask_req", {31'h0, imem_req_valid}, 32'd1);
      check("mask_addr", imem_addr, 32'h100);
      tick();
      tick();
      check("mask_instr", instr, 32'h0010_0013);
      check("mask_instr_pc", instr_pc, 32'h100);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage upstream of decode and the immediate extender.
- Owns the PC register and issues one outstanding read at a time to instruction memory over a valid/ready request plus response-valid interface.
- Captures the returned word and presents instr/pc/pc+4 to decode with a valid/ready handshake.
- Accepts branch/jump redirects (PCTarget from execute) at any time and squashes in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  fetch address; word aligned
- imem_rsp_valid  in  1  read data valid; at most one per accepted request, arriving ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instr/instr_pc/instr_pcplus4 valid
- instr_ready  in  1  decode consumes this cycle
- instr  out  32  instruction to decode; bits [31:7] feed the extender
- instr_pc  out  32  PC of instr
- instr_pcplus4  out  32  instr_pc + 4, modulo 2^32
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target address
- fetch_fault  out  1  misaligned-target trap flag; constant 0 unless the feature is enabled

Behaviour:
- Reset (while reset=1):
  - state=S_IDLE, pc=RESET_PC, kill=0.
  - imem_req_valid=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, instr_pcplus4=0, fetch_fault=0.
  - Reset mid-transaction abandons the transaction; any late imem_rsp_valid is ignored while state is S_IDLE.
- States:
  - S_IDLE → S_REQ unconditionally, one cycle after reset deasserts.
  - S_REQ:
    - imem_req_valid=1, imem_addr=pc.
    - req_valid & req_ready → S_WAIT.
  - S_WAIT:
    - On rsp_valid with kill=0: instr←rsp_data, instr_pc←pc, instr_pcplus4←pc+4, pc←pc+4 → S_HOLD.
    - On rsp_valid with kill=1: discard the data, kill←0 → S_REQ.
  - S_HOLD:
    - instr_valid=1.
    - instr_ready → S_REQ; instr_valid drops the next cycle.
- imem_req_valid is asserted only in S_REQ and holds with a stable address until accepted.
- The only exception is a redirect, which updates imem_addr the next cycle.
- Latency: request accept → instr_valid is ≥2 cycles (response cycle + capture register). Single outstanding request; no prefetch.
- Redirect (highest priority, any state except S_IDLE):
  - pc←redirect_pc.
  - S_REQ without handshake: stays S_REQ with the new address.
  - S_REQ with handshake in the same cycle: → S_WAIT, kill←1.
  - S_WAIT with no rsp this cycle: kill←1.
  - S_WAIT with rsp this cycle: data dropped → S_REQ.
  - S_HOLD: held instr dropped, instr_valid=0 next cycle → S_REQ. A simultaneous instr_ready still counts as consumed.
- instr returns to NOP_INSTR whenever the stage leaves S_HOLD.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- redirect_pc[1:0] are forced to 0 when the feature is disabled.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - A redirect with redirect_pc[1:0]≠0 moves the stage to S_TRAP.
  - fetch_fault=1, sticky until reset; no requests issued; instr_valid=0.
  - An outstanding response is absorbed silently.
- When undefined: no S_TRAP state, fetch_fault tied 0, low bits masked as above.

Decomposition:
- riscv_pkg: state encodings (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_TRAP), NOP_INSTR constant, PC_STEP=4.
- Sub-module pc_next_sel: combinational choice among pc, pc+4 and redirect_pc, including low-bit masking.
- The FSM and registers stay in fetch_unit.

Test Plan:
- Reset release, memory always ready with 1-cycle response returning 32'h00500093 at address 0:
  - first imem_addr=0 in the cycle after S_IDLE;
  - instr_valid two cycles after acceptance with instr=32'h00500093, instr_pc=0, instr_pcplus4=4.
- instr_ready held low for 5 cycles in S_HOLD → instr stable, no new request; ready high → next request at address 4.
- Redirect to 32'h0000_0100 while in S_WAIT → stale response discarded, never seen by decode; next request at 0x100.
- Redirect in S_HOLD coincident with instr_ready → instr_valid low next cycle; next imem_addr=0x100.
- imem_req_ready low for 3 cycles → imem_req_valid and imem_addr stable throughout; reset asserted in S_WAIT → late response ignored; fetch restarts at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → fetch_fault=1, no further requests until reset. Without it, the next request goes to 0x100.
